// File: rtl/snake_game_ctrl_pkg.sv
// Shared encodings and default dimensions for the Snake game sequencer.
package snake_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_RUNNING  = 3'b001,
        ST_FINISHED = 3'b010,
        ST_CLEANUP  = 3'b100
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam int unsigned DEF_GRID_COLS       = 20;
    localparam int unsigned DEF_GRID_ROWS       = 15;
    localparam int unsigned DEF_FRAMES_PER_MOVE = 10;
    localparam int unsigned DEF_MAX_LEN         = 32;
    localparam logic [5:0]  START_LEN           = 6'd3;

    // A request for the opposite of the committed heading would fold the snake onto itself.
    function automatic dir_t dir_reverse(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Boundary between the game sequencer and the VGA datapath / body checkers.
interface snake_game_ctrl_if;
    import snake_game_ctrl_pkg::*;

    logic       vsync;
    logic       start;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       self_hit;
    logic       food_hit;

    state_t     state;
    logic       move_tick;
    logic [5:0] head_x;
    logic [5:0] head_y;
    dir_t       dir;
    logic [5:0] length;
    logic       grow;
    logic       clr_en;
    logic [5:0] clr_addr;

    modport master (
        input  vsync, start, up, down, left, right, self_hit, food_hit,
        output state, move_tick, head_x, head_y, dir, length, grow, clr_en, clr_addr
    );

    modport slave (
        output vsync, start, up, down, left, right, self_hit, food_hit,
        input  state, move_tick, head_x, head_y, dir, length, grow, clr_en, clr_addr
    );

endinterface

// File: rtl/snake_game_ctrl_frame_timer.sv
// VSync falling-edge detector and frame counter; pulses step on the edge that completes a move period.
module snake_game_ctrl_frame_timer #(
    parameter int unsigned c_FRAMES_PER_MOVE = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    input  logic enable,
    input  logic clear,
    output logic step
);

    localparam int unsigned    CW   = (c_FRAMES_PER_MOVE > 1) ? $clog2(c_FRAMES_PER_MOVE) : 1;
    localparam logic [CW-1:0]  LAST = CW'(c_FRAMES_PER_MOVE - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic          vsync_d_r;
    logic [CW-1:0] cnt_r;
    logic          fall_s;

    assign fall_s = vsync_d_r & ~vsync;
    assign step   = enable & fall_s & (cnt_r == LAST);

    // Edge history and frame count; the count wraps on the same edge that fires step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            vsync_d_r <= vsync;
            if (clear) begin
                cnt_r <= '0;
            end else if (enable && fall_s) begin
                if (cnt_r == LAST) begin
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + ONE;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: main FSM, direction arbiter, head stepping with wall detect, body-RAM sweep.
module snake_game_ctrl
    import snake_game_ctrl_pkg::*;
#(
    parameter int unsigned c_GRID_COLS       = DEF_GRID_COLS,
    parameter int unsigned c_GRID_ROWS       = DEF_GRID_ROWS,
    parameter int unsigned c_FRAMES_PER_MOVE = DEF_FRAMES_PER_MOVE,
    parameter int unsigned c_MAX_LEN         = DEF_MAX_LEN
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    snake_game_ctrl_if.master  bus
);

    localparam logic [5:0] HOME_X    = 6'(c_GRID_COLS / 2);
    localparam logic [5:0] HOME_Y    = 6'(c_GRID_ROWS / 2);
    localparam logic [5:0] LAST_COL  = 6'(c_GRID_COLS - 1);
    localparam logic [5:0] LAST_ROW  = 6'(c_GRID_ROWS - 1);
    localparam logic [5:0] MAX_LEN   = 6'(c_MAX_LEN);
    localparam logic [5:0] LAST_ADDR = 6'(c_MAX_LEN - 1);

    state_t     state_r;
    logic [5:0] head_x_r;
    logic [5:0] head_y_r;
    dir_t       dir_r;
    dir_t       pending_r;
    logic [5:0] length_r;
    logic       move_tick_r;
    logic       check_r;
    logic       grow_r;
    logic       clr_en_r;
    logic [5:0] clr_addr_r;
    logic       start_d_r;

    logic       start_rise_s;
    logic       run_s;
    logic       clr_last_s;
    logic       step_s;
    logic       req_valid_s;
    dir_t       req_dir_s;
    logic       accept_s;
    logic       wall_s;
    logic [5:0] next_x_s;
    logic [5:0] next_y_s;

    assign start_rise_s = bus.start & ~start_d_r;
    assign run_s        = (state_r == ST_RUNNING);
    assign clr_last_s   = (state_r == ST_CLEANUP) && (clr_addr_r == LAST_ADDR);
    assign accept_s     = req_valid_s && (req_dir_s != dir_reverse(dir_r));

    snake_game_ctrl_frame_timer #(
        .c_FRAMES_PER_MOVE (c_FRAMES_PER_MOVE)
    ) u_frame_timer (
        .clk    (i_Clk),
        .rst_n  (i_Rst_L),
        .vsync  (bus.vsync),
        .enable (run_s),
        .clear  (clr_last_s),
        .step   (step_s)
    );

    // Fixed-priority button pick: Up > Down > Left > Right.
    always_comb begin
        req_valid_s = 1'b1;
        req_dir_s   = DIR_RIGHT;
        if (bus.up) begin
            req_dir_s = DIR_UP;
        end else if (bus.down) begin
            req_dir_s = DIR_DOWN;
        end else if (bus.left) begin
            req_dir_s = DIR_LEFT;
        end else if (bus.right) begin
            req_dir_s = DIR_RIGHT;
        end else begin
            req_valid_s = 1'b0;
        end
    end

    // Candidate head position for the pending heading, flagging a step off the playfield.
    always_comb begin
        next_x_s = head_x_r;
        next_y_s = head_y_r;
        wall_s   = 1'b0;
        case (pending_r)
            DIR_UP: begin
                if (head_y_r == 6'd0) wall_s = 1'b1;
                else                  next_y_s = head_y_r - 6'd1;
            end
            DIR_DOWN: begin
                if (head_y_r == LAST_ROW) wall_s = 1'b1;
                else                      next_y_s = head_y_r + 6'd1;
            end
            DIR_LEFT: begin
                if (head_x_r == 6'd0) wall_s = 1'b1;
                else                  next_x_s = head_x_r - 6'd1;
            end
            DIR_RIGHT: begin
                if (head_x_r == LAST_COL) wall_s = 1'b1;
                else                      next_x_s = head_x_r + 6'd1;
            end
            default: begin
                wall_s = 1'b1;
            end
        endcase
    end

    // Main game FSM with all game-visible state and pulses registered.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r     <= ST_IDLE;
            head_x_r    <= HOME_X;
            head_y_r    <= HOME_Y;
            dir_r       <= DIR_RIGHT;
            pending_r   <= DIR_RIGHT;
            length_r    <= START_LEN;
            move_tick_r <= 1'b0;
            check_r     <= 1'b0;
            grow_r      <= 1'b0;
            clr_en_r    <= 1'b0;
            clr_addr_r  <= 6'd0;
            start_d_r   <= 1'b0;
        end else begin
            start_d_r   <= bus.start;
            move_tick_r <= 1'b0;
            grow_r      <= 1'b0;
            // Checker results refer to the head registered one cycle before they arrive.
            check_r     <= move_tick_r;
            case (state_r)
                ST_IDLE: begin
                    if (start_rise_s) begin
                        state_r    <= ST_CLEANUP;
                        clr_en_r   <= 1'b1;
                        clr_addr_r <= 6'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLEANUP: begin
                    if (clr_addr_r == LAST_ADDR) begin
                        state_r    <= ST_RUNNING;
                        clr_en_r   <= 1'b0;
                        clr_addr_r <= 6'd0;
                        head_x_r   <= HOME_X;
                        head_y_r   <= HOME_Y;
                        dir_r      <= DIR_RIGHT;
                        pending_r  <= DIR_RIGHT;
                        length_r   <= START_LEN;
                    end else begin
                        clr_addr_r <= clr_addr_r + 6'd1;
                    end
                end
                ST_RUNNING: begin
                    if (accept_s) begin
                        pending_r <= req_dir_s;
                    end else begin
                        pending_r <= pending_r;
                    end
                    if (check_r && bus.self_hit) begin
                        state_r <= ST_FINISHED;
                    end else begin
                        if (check_r && bus.food_hit) begin
                            grow_r <= 1'b1;
                            if (length_r != MAX_LEN) begin
                                length_r <= length_r + 6'd1;
                            end else begin
                                length_r <= length_r;
                            end
                        end else begin
                            grow_r <= 1'b0;
                        end
                        if (step_s && wall_s) begin
                            state_r <= ST_FINISHED;
                        end else if (step_s) begin
                            head_x_r    <= next_x_s;
                            head_y_r    <= next_y_s;
                            dir_r       <= pending_r;
                            move_tick_r <= 1'b1;
                        end else begin
                            state_r <= ST_RUNNING;
                        end
                    end
                end
                ST_FINISHED: begin
                    if (start_rise_s) begin
                        state_r    <= ST_CLEANUP;
                        clr_en_r   <= 1'b1;
                        clr_addr_r <= 6'd0;
                    end else begin
                        state_r <= ST_FINISHED;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    head_x_r   <= HOME_X;
                    head_y_r   <= HOME_Y;
                    dir_r      <= DIR_RIGHT;
                    pending_r  <= DIR_RIGHT;
                    length_r   <= START_LEN;
                    clr_en_r   <= 1'b0;
                    clr_addr_r <= 6'd0;
                end
            endcase
        end
    end

    assign bus.state     = state_r;
    assign bus.move_tick = move_tick_r;
    assign bus.head_x    = head_x_r;
    assign bus.head_y    = head_y_r;
    assign bus.dir       = dir_r;
    assign bus.length    = length_r;
    assign bus.grow      = grow_r;
    assign bus.clr_en    = clr_en_r;
    assign bus.clr_addr  = clr_addr_r;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: direction-vector table plus scoreboarded move ticks.
module tb_snake_game_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snake_game_ctrl_if bus();

    snake_game_ctrl #(
        .c_GRID_COLS       (20),
        .c_GRID_ROWS       (15),
        .c_FRAMES_PER_MOVE (2),
        .c_MAX_LEN         (32)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0] btn;   // {up, down, left, right}
        int         ex;
        int         ey;
        int         ed;
    } vec_t;

    typedef struct {
        int x;
        int y;
        int d;
    } exp_t;

    localparam int S_IDLE = 0, S_RUN = 1, S_FIN = 2, S_CLN = 4;
    localparam int D_UP = 0, D_DOWN = 1, D_LEFT = 2, D_RIGHT = 3;

    vec_t vecs[10];
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   tick_cnt = 0;
    int   t0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int x, input int y, input int d);
        exp_t e;
        e.x = x;
        e.y = y;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Two VSync falling edges = one move period; returns on the negedge where the tick is visible.
    task automatic step();
        repeat (2) begin
            bus.vsync = 1'b1;
            cyc(1);
            bus.vsync = 1'b0;
            cyc(1);
        end
    endtask

    task automatic wait_state(input int st, input string name);
        int n;
        n = 0;
        while (int'(bus.state) != st && n < 100) begin
            cyc(1);
            n++;
        end
        chk(name, int'(bus.state), st);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b0000, 11, 7, D_RIGHT};
        vecs[1] = '{4'b0000, 12, 7, D_RIGHT};
        vecs[2] = '{4'b0010, 13, 7, D_RIGHT};  // Left reverses Right: ignored
        vecs[3] = '{4'b1001, 13, 6, D_UP};     // Up beats Right
        vecs[4] = '{4'b0100, 13, 5, D_UP};     // Down reverses Up: ignored
        vecs[5] = '{4'b0010, 12, 5, D_LEFT};
        vecs[6] = '{4'b0001, 11, 5, D_LEFT};   // Right reverses Left: ignored
        vecs[7] = '{4'b0110, 11, 6, D_DOWN};   // Down beats Left
        vecs[8] = '{4'b1100, 11, 7, D_DOWN};   // Up wins arbitration but reverses Down
        vecs[9] = '{4'b0001, 12, 7, D_RIGHT};

        bus.vsync = 1'b0; bus.start = 1'b0;
        bus.up = 1'b0; bus.down = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
        bus.self_hit = 1'b0; bus.food_hit = 1'b0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rst_n && bus.move_tick) begin
                    tick_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("tick_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tick_head_x", int'(bus.head_x), e.x);
                        chk("tick_head_y", int'(bus.head_y), e.y);
                        chk("tick_dir", int'(bus.dir), e.d);
                    end
                end
            end
        join_none

        cyc(3);
        chk("rst_state", int'(bus.state), S_IDLE);
        chk("rst_head_x", int'(bus.head_x), 10);
        chk("rst_head_y", int'(bus.head_y), 7);
        chk("rst_dir", int'(bus.dir), D_RIGHT);
        chk("rst_length", int'(bus.length), 3);
        chk("rst_clr_en", int'(bus.clr_en), 0);
        chk("rst_clr_addr", int'(bus.clr_addr), 0);
        chk("rst_tick", int'(bus.move_tick), 0);
        chk("rst_grow", int'(bus.grow), 0);
        rst_n = 1'b1;
        bus.vsync = 1'b1;
        cyc(1);
        bus.vsync = 1'b0;
        cyc(2);
        chk("idle_ignores_vsync", int'(bus.state), S_IDLE);

        // Start held high for the whole sweep must not retrigger anything.
        bus.start = 1'b1;
        cyc(1);
        for (int i = 0; i < 32; i++) begin
            chk("clr_state", int'(bus.state), S_CLN);
            chk("clr_en", int'(bus.clr_en), 1);
            chk("clr_addr", int'(bus.clr_addr), i);
            cyc(1);
        end
        chk("clr_done_state", int'(bus.state), S_RUN);
        chk("clr_done_en", int'(bus.clr_en), 0);
        chk("clr_done_addr", int'(bus.clr_addr), 0);
        chk("run_head_x", int'(bus.head_x), 10);
        chk("run_head_y", int'(bus.head_y), 7);
        bus.start = 1'b0;

        for (int i = 0; i < 10; i++) begin
            {bus.up, bus.down, bus.left, bus.right} = vecs[i].btn;
            cyc(1);
            {bus.up, bus.down, bus.left, bus.right} = 4'b0000;
            push_exp(vecs[i].ex, vecs[i].ey, vecs[i].ed);
            step();
            cyc(1);
        end

        for (int x = 13; x <= 19; x++) begin
            push_exp(x, 7, D_RIGHT);
            step();
            cyc(1);
        end
        t0 = tick_cnt;
        step();
        chk("wall_state", int'(bus.state), S_FIN);
        chk("wall_head_x", int'(bus.head_x), 19);
        chk("wall_head_y", int'(bus.head_y), 7);
        step();
        chk("fin_frozen_x", int'(bus.head_x), 19);
        chk("wall_no_tick", tick_cnt, t0);

        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        wait_state(S_RUN, "restart_running");
        chk("restart_head_x", int'(bus.head_x), 10);
        chk("restart_length", int'(bus.length), 3);
        chk("restart_dir", int'(bus.dir), D_RIGHT);

        // Self and food together: game ends, no growth; start is held across the transition.
        push_exp(11, 7, D_RIGHT);
        bus.start = 1'b1;
        step();
        cyc(1);
        bus.self_hit = 1'b1;
        bus.food_hit = 1'b1;
        cyc(1);
        chk("self_state", int'(bus.state), S_FIN);
        chk("self_no_grow", int'(bus.grow), 0);
        chk("self_length", int'(bus.length), 3);
        bus.self_hit = 1'b0;
        bus.food_hit = 1'b0;
        cyc(3);
        chk("start_held_no_retrigger", int'(bus.state), S_FIN);
        bus.start = 1'b0;
        cyc(1);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        wait_state(S_RUN, "second_restart");

        push_exp(11, 7, D_RIGHT);
        step();
        cyc(1);
        bus.food_hit = 1'b1;
        cyc(1);
        chk("food_grow", int'(bus.grow), 1);
        chk("food_length", int'(bus.length), 4);
        bus.food_hit = 1'b0;
        cyc(1);
        chk("grow_one_cycle", int'(bus.grow), 0);
        chk("food_length_hold", int'(bus.length), 4);
        bus.food_hit = 1'b1;
        cyc(2);
        chk("food_outside_window", int'(bus.grow), 0);
        chk("food_outside_len", int'(bus.length), 4);
        bus.food_hit = 1'b0;
        bus.start = 1'b1;
        cyc(2);
        chk("run_ignores_start", int'(bus.state), S_RUN);
        bus.start = 1'b0;

        rst_n = 1'b0;
        #1;
        chk("rst_from_run", int'(bus.state), S_IDLE);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(10);
        chk("mid_clr_addr", int'(bus.clr_addr), 10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", int'(bus.state), S_IDLE);
        chk("mid_rst_clr_en", int'(bus.clr_en), 0);
        chk("mid_rst_clr_addr", int'(bus.clr_addr), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("post_rst_idle", int'(bus.state), S_IDLE);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
